counter_bank: RTL and testbench
===============================

// Module: counter_bank
// PURPOSE
//  - N independent WIDTH-bit programmable counters in one block.
//  - Successor to the single-channel clear/enable counter. Adds per-channel up/down
//    direction, parallel load, and wrap / saturate / one-shot modes.
//  - Adds a registered terminal-count pulse and a sticky wrap flag with acknowledge.
//  - Used by timer/event-count logic that needs several channels behind one instance.
// PARAMETERS
//  - WIDTH     8   counter width per channel, >= 2
//  - NCH       4   number of channels, >= 1
// PORTS
//  - clk       in   1          clock, all state on rising edge
//  - rst_n     in   1          reset, asynchronous, active-low
//  - clr       in   NCH        per-channel synchronous clear (highest priority)
//  - load      in   NCH        per-channel parallel load
//  - load_val  in   NCH*WIDTH  load values; channel i uses [i*WIDTH +: WIDTH]
//  - en        in   NCH        per-channel count enable
//  - dir       in   NCH        1 = count up, 0 = count down
//  - mode      in   2*NCH      per-channel mode: 00 WRAP, 01 SAT, 10 ONESHOT, 11 = WRAP
//  - max_val   in   NCH*WIDTH  per-channel terminal value (upper bound)
//  - wrap_ack  in   NCH        clears the sticky wrap flag
//  - cnt       out  NCH*WIDTH  counter values
//  - eq        out  NCH        combinational: cnt == max_val
//  - tc        out  NCH        registered 1-cycle terminal-count pulse
//  - wrapped   out  NCH        sticky: channel wrapped since last ack
//  - done      out  NCH        ONESHOT channel has finished and is halted
// BEHAVIOUR
//  - Reset: cnt = 0, tc = 0, wrapped = 0, done = 0, channel state = RUN.
//  - Priority per channel and cycle: clr > load > en. No enable means hold.
//  - clr:
//    - cnt <= 0, done <= 0, state <= RUN.
//    - wrapped is unaffected.
//  - load:
//    - cnt <= min(load_val, max_val), done <= 0, state <= RUN.
//  - Terminal step:
//    - Up: an enabled step with cnt >= max_val. Covers max_val lowered below cnt mid-run.
//    - Down: an enabled step with cnt == 0.
//  - Non-terminal step: cnt +/- 1, no flags.
//  - Terminal step, WRAP mode:
//    - Up: cnt <= 0. Down: cnt <= max_val.
//    - tc pulses; wrapped set.
//  - Terminal step, SAT mode:
//    - Up: cnt <= max_val (clamps if cnt > max_val). Down: cnt held at 0.
//    - tc pulses only on the first terminal step after arrival.
//    - Further enabled steps at the limit produce no tc. Leaving the limit (clr, load,
//      or a dir change with en) re-arms tc.
//  - Terminal step, ONESHOT mode:
//    - Up: cnt <= max_val, or held at 0 if down.
//    - tc pulses; state RUN -> DONE; done = 1.
//    - In DONE, en is ignored. Only clr or load returns the channel to RUN.
//  - tc timing: registered, asserted the cycle after the terminal step, exactly 1 cycle.
//  - wrapped:
//    - Set on a WRAP-mode terminal step; cleared by wrap_ack.
//    - Set and ack in the same cycle: set wins.
//  - Mode change mid-run:
//    - Takes effect on the next step.
//    - Changing away from ONESHOT while in DONE clears done and returns to RUN.
//  - Arithmetic: all WIDTH-bit unsigned, no carry out. max_val = 0 is a legal
//    terminal-every-step case.
//  - Channels are fully independent; there is no cross-channel interaction.
//  - Reset mid-operation: all state returns to reset values immediately, asynchronously.
// STRUCTURE
//  - Package counter_bank_pkg:
//    - mode encodings MODE_WRAP / MODE_SAT / MODE_ONESHOT as localparams.
//    - Channel state encoding RUN / DONE, plus the SAT tc-armed bit.
//  - Sub-module counter_chan: one channel (cnt, state, tc, wrapped, armed).
//    - Instantiated NCH times in a generate loop.
//    - counter_bank only slices the buses.
// TESTING
//  - Reset:
//    - Assert rst_n low mid-count.
//    - All cnt/tc/wrapped/done = 0 asynchronously; counting resumes from 0 after release.
//  - WRAP up, WIDTH = 8, max_val = 5, en held:
//    - cnt 0,1,..,5,0.
//    - tc high the single cycle after the 5->0 step; wrapped sticky until wrap_ack.
//  - WRAP down, max_val = 3, load 1:
//    - cnt 1,0,3,2.
//    - tc after the 0->3 step.
//    - wrap_ack together with the next wrap keeps wrapped = 1.
//  - SAT up, max_val = 4:
//    - cnt saturates at 4; tc exactly once.
//    - Lower max_val to 2 with en: cnt -> 2, tc once more.
//  - ONESHOT, max_val = 3:
//    - Reaches 3, done = 1, en ignored for 10 cycles.
//    - load 1 re-arms; counts to 3 again.
//  - Priority and independence, NCH = 4:
//    - clr, load, en all high on ch0 -> cnt = 0.
//    - load_val = 200 with max_val = 9 on ch1 -> cnt = 9.
//    - ch2/ch3 continue unaffected.

Source files
------------

// File: rtl/counter_bank_pkg.sv
// Shared encodings for the counter bank: channel modes, channel run state and
// the reset value of the saturate-mode terminal-count arming bit.
package counter_bank_pkg;

    localparam logic [1:0] MODE_WRAP    = 2'b00;
    localparam logic [1:0] MODE_SAT     = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } chan_state_e;

    localparam logic ARMED_RST = 1'b1;

endpackage

// File: rtl/counter_chan.sv
// One programmable counter channel: clear/load/step with wrap, saturate and
// one-shot terminal behaviour, registered tc pulse and sticky wrap flag.
module counter_chan
    import counter_bank_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    input  logic             dir_i,
    input  logic [1:0]       mode_i,
    input  logic [WIDTH-1:0] max_val_i,
    input  logic             wrap_ack_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             eq_o,
    output logic             tc_o,
    output logic             wrapped_o,
    output logic             done_o
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    chan_state_e      state_q, state_d;
    logic             tc_q, tc_d;
    logic             wrapped_q, wrapped_d;
    logic             armed_q, armed_d;

    logic             halted;
    logic             terminal;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] load_clamped;

    // Up is terminal at or beyond max_val so a lowered max_val still catches a running count.
    assign terminal     = dir_i ? (cnt_q >= max_val_i) : (cnt_q == '0);
    assign limit        = dir_i ? max_val_i : '0;
    assign load_clamped = (load_val_i > max_val_i) ? max_val_i : load_val_i;
    assign halted       = (state_q == ST_DONE) && (mode_i == MODE_ONESHOT);

    always_comb begin
        cnt_d     = cnt_q;
        state_d   = state_q;
        tc_d      = 1'b0;
        armed_d   = armed_q;
        wrapped_d = wrapped_q & ~wrap_ack_i;
        if (clr_i) begin
            cnt_d   = '0;
            state_d = ST_RUN;
            armed_d = 1'b1;
        end else if (load_i) begin
            cnt_d   = load_clamped;
            state_d = ST_RUN;
            armed_d = 1'b1;
        end else begin
            if (state_q == ST_DONE && mode_i != MODE_ONESHOT) begin
                state_d = ST_RUN;
            end
            if (en_i && !halted) begin
                armed_d = 1'b1;
                if (!terminal) begin
                    cnt_d = dir_i ? (cnt_q + ONE) : (cnt_q - ONE);
                end else begin
                    case (mode_i)
                        MODE_SAT: begin
                            // A clamp onto a moved limit counts as a fresh arrival.
                            tc_d    = armed_q | (cnt_q != limit);
                            cnt_d   = limit;
                            armed_d = 1'b0;
                        end
                        MODE_ONESHOT: begin
                            tc_d    = 1'b1;
                            cnt_d   = limit;
                            state_d = ST_DONE;
                        end
                        default: begin
                            tc_d      = 1'b1;
                            cnt_d     = dir_i ? '0 : max_val_i;
                            wrapped_d = 1'b1;
                        end
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            state_q   <= ST_RUN;
            tc_q      <= 1'b0;
            wrapped_q <= 1'b0;
            armed_q   <= ARMED_RST;
        end else begin
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            tc_q      <= tc_d;
            wrapped_q <= wrapped_d;
            armed_q   <= armed_d;
        end
    end

    assign cnt_o     = cnt_q;
    assign eq_o      = (cnt_q == max_val_i);
    assign tc_o      = tc_q;
    assign wrapped_o = wrapped_q;
    assign done_o    = (state_q == ST_DONE);

endmodule

// File: rtl/counter_bank.sv
// Bank of NCH independent programmable counters; this level only slices the
// shared buses onto one counter_chan per channel.
module counter_bank
    import counter_bank_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NCH   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH-1:0]       clr,
    input  logic [NCH-1:0]       load,
    input  logic [NCH*WIDTH-1:0] load_val,
    input  logic [NCH-1:0]       en,
    input  logic [NCH-1:0]       dir,
    input  logic [2*NCH-1:0]     mode,
    input  logic [NCH*WIDTH-1:0] max_val,
    input  logic [NCH-1:0]       wrap_ack,
    output logic [NCH*WIDTH-1:0] cnt,
    output logic [NCH-1:0]       eq,
    output logic [NCH-1:0]       tc,
    output logic [NCH-1:0]       wrapped,
    output logic [NCH-1:0]       done
);

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        counter_chan #(
            .WIDTH(WIDTH)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .clr_i     (clr[i]),
            .load_i    (load[i]),
            .load_val_i(load_val[i*WIDTH +: WIDTH]),
            .en_i      (en[i]),
            .dir_i     (dir[i]),
            .mode_i    (mode[2*i +: 2]),
            .max_val_i (max_val[i*WIDTH +: WIDTH]),
            .wrap_ack_i(wrap_ack[i]),
            .cnt_o     (cnt[i*WIDTH +: WIDTH]),
            .eq_o      (eq[i]),
            .tc_o      (tc[i]),
            .wrapped_o (wrapped[i]),
            .done_o    (done[i])
        );
    end

endmodule

// File: tb/tb_counter_bank.sv
// Bench for counter_bank: a per-channel behavioural model checked every cycle,
// directed sequences with hand-computed values, then randomized traffic.
module tb_counter_bank;

    localparam int W   = 8;
    localparam int NCH = 4;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NCH-1:0]       clr = '0, load = '0, en = '0, dir = '0, wrap_ack = '0;
    logic [2*NCH-1:0]     mode = '0;
    logic [NCH*W-1:0]     load_val = '0, max_val = '0;
    logic [NCH*W-1:0]     cnt;
    logic [NCH-1:0]       eq, tc, wrapped, done;

    int vecs = 0;
    int errs = 0;

    counter_bank #(.WIDTH(W), .NCH(NCH)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .dir(dir), .mode(mode), .max_val(max_val), .wrap_ack(wrap_ack),
        .cnt(cnt), .eq(eq), .tc(tc), .wrapped(wrapped), .done(done)
    );

    always #5 clk = ~clk;

    // Model state per channel; "fired" = SAT channel already reported this limit.
    typedef struct packed {
        int cnt;
        bit tc;
        bit wrapped;
        bit done;
        bit fired;
    } mst_t;

    mst_t m [NCH];

    function automatic mst_t model_next(int c, mst_t s);
        mst_t n = s;
        int mx = int'(max_val[c*W +: W]);
        int lv = int'(load_val[c*W +: W]);
        int md = int'(mode[2*c +: 2]);
        bit up = dir[c];
        bit terminal;
        int target;
        n.tc = 1'b0;
        if (wrap_ack[c]) n.wrapped = 1'b0;
        if (clr[c]) begin
            n.cnt = 0; n.done = 1'b0; n.fired = 1'b0;
        end else if (load[c]) begin
            n.cnt = (lv < mx) ? lv : mx; n.done = 1'b0; n.fired = 1'b0;
        end else begin
            if (s.done && md != 2) n.done = 1'b0;
            if (en[c] && !(s.done && md == 2)) begin
                n.fired  = 1'b0;
                terminal = up ? (s.cnt >= mx) : (s.cnt == 0);
                target   = up ? mx : 0;
                if (!terminal) begin
                    n.cnt = up ? s.cnt + 1 : s.cnt - 1;
                end else if (md == 1) begin
                    n.tc    = !s.fired || (s.cnt != target);
                    n.cnt   = target;
                    n.fired = 1'b1;
                end else if (md == 2) begin
                    n.tc = 1'b1; n.cnt = target; n.done = 1'b1;
                end else begin
                    n.tc = 1'b1; n.cnt = up ? 0 : mx; n.wrapped = 1'b1;
                end
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NCH; c++) m[c] <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) m[c] <= model_next(c, m[c]);
        end
    end

    task automatic check(input string nm, input int c, input int act, input int exp);
        vecs++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s ch%0d actual=%0d required=%0d at %0t", nm, c, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            for (int c = 0; c < NCH; c++) begin
                check("model_cnt", c, int'(cnt[c*W +: W]), m[c].cnt);
                check("model_eq", c, int'(eq[c]), int'(m[c].cnt == int'(max_val[c*W +: W])));
                check("model_tc", c, int'(tc[c]), int'(m[c].tc));
                check("model_wrapped", c, int'(wrapped[c]), int'(m[c].wrapped));
                check("model_done", c, int'(done[c]), int'(m[c].done));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int cnt_of(int c);
        return int'(cnt[c*W +: W]);
    endfunction

    initial begin
        // ch2/ch3 free-run in the background to show channel independence.
        for (int c = 2; c < NCH; c++) begin
            en[c] = 1'b1; dir[c] = 1'b1; max_val[c*W +: W] = 8'd7;
        end
        mode[2*3 +: 2] = 2'b01;
        #12;
        check("reset_cnt", -1, int'(cnt), 0);
        check("reset_flags", -1, int'({tc, wrapped, done}), 0);
        rst_n = 1'b1;
        tick();

        // WRAP up, max 5
        max_val[0 +: W] = 8'd5; mode[0 +: 2] = 2'b00; dir[0] = 1'b1; en[0] = 1'b1;
        for (int i = 1; i <= 5; i++) tick();
        check("wrap_up_at5", 0, cnt_of(0), 5);
        check("wrap_up_eq", 0, int'(eq[0]), 1);
        tick();
        check("wrap_up_0", 0, cnt_of(0), 0);
        check("wrap_up_tc", 0, int'(tc[0]), 1);
        check("wrap_up_wrapped", 0, int'(wrapped[0]), 1);
        tick();
        check("wrap_up_tc_1cyc", 0, int'(tc[0]), 0);
        check("wrap_up_sticky", 0, int'(wrapped[0]), 1);
        en[0] = 1'b0; wrap_ack[0] = 1'b1;
        tick();
        wrap_ack[0] = 1'b0;
        check("wrap_ack_clears", 0, int'(wrapped[0]), 0);

        // WRAP down, max 3, load 1
        max_val[0 +: W] = 8'd3; load_val[0 +: W] = 8'd1; load[0] = 1'b1; dir[0] = 1'b0; en[0] = 1'b1;
        tick();
        load[0] = 1'b0;
        check("wrap_dn_load", 0, cnt_of(0), 1);
        tick();
        check("wrap_dn_0", 0, cnt_of(0), 0);
        tick();
        check("wrap_dn_3", 0, cnt_of(0), 3);
        check("wrap_dn_tc", 0, int'(tc[0]), 1);
        tick();
        check("wrap_dn_2", 0, cnt_of(0), 2);
        tick(); tick();
        wrap_ack[0] = 1'b1;
        tick();
        wrap_ack[0] = 1'b0; en[0] = 1'b0;
        check("wrap_set_beats_ack", 0, int'(wrapped[0]), 1);
        check("wrap_dn_tc2", 0, int'(tc[0]), 1);

        // SAT up, max 4
        clr[0] = 1'b1;
        tick();
        clr[0] = 1'b0;
        max_val[0 +: W] = 8'd4; mode[0 +: 2] = 2'b01; dir[0] = 1'b1; en[0] = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            check("sat_tc_once", 0, int'(tc[0]), int'(i == 5));
        end
        check("sat_hold", 0, cnt_of(0), 4);
        max_val[0 +: W] = 8'd2;
        tick();
        check("sat_lower_cnt", 0, cnt_of(0), 2);
        check("sat_lower_tc", 0, int'(tc[0]), 1);
        tick();
        check("sat_lower_tc_off", 0, int'(tc[0]), 0);

        // ONESHOT, max 3
        clr[0] = 1'b1;
        tick();
        clr[0] = 1'b0;
        max_val[0 +: W] = 8'd3; mode[0 +: 2] = 2'b10;
        for (int i = 1; i <= 4; i++) tick();
        check("os_cnt", 0, cnt_of(0), 3);
        check("os_done", 0, int'(done[0]), 1);
        check("os_tc", 0, int'(tc[0]), 1);
        for (int i = 0; i < 10; i++) tick();
        check("os_halted_cnt", 0, cnt_of(0), 3);
        check("os_halted_done", 0, int'(done[0]), 1);
        load_val[0 +: W] = 8'd1; load[0] = 1'b1;
        tick();
        load[0] = 1'b0;
        check("os_reload", 0, cnt_of(0), 1);
        check("os_reload_done", 0, int'(done[0]), 0);
        tick(); tick(); tick();
        check("os_again_done", 0, int'(done[0]), 1);

        // Priority and clamp-on-load
        mode[0 +: 2] = 2'b00; max_val[0 +: W] = 8'd50; load_val[0 +: W] = 8'd20;
        clr[0] = 1'b1; load[0] = 1'b1; en[0] = 1'b1;
        max_val[W +: W] = 8'd9; load_val[W +: W] = 8'd200; load[1] = 1'b1;
        tick();
        clr[0] = 1'b0; load[0] = 1'b0; load[1] = 1'b0;
        check("prio_clr", 0, cnt_of(0), 0);
        check("load_clamp", 1, cnt_of(1), 9);

        // Async reset mid-count
        max_val[0 +: W] = 8'd200;
        tick(); tick();
        #3 rst_n = 1'b0;
        #1;
        check("areset_cnt", -1, int'(cnt), 0);
        check("areset_flags", -1, int'({tc, wrapped, done}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("resume_from_0", 0, cnt_of(0), 1);

        // Randomized traffic on all channels
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < NCH; c++) begin
                clr[c]      = ($urandom_range(99) < 4);
                load[c]     = ($urandom_range(99) < 8);
                en[c]       = ($urandom_range(99) < 75);
                wrap_ack[c] = ($urandom_range(99) < 10);
                if ($urandom_range(99) < 10) dir[c] = ~dir[c];
                if ($urandom_range(99) < 5) mode[2*c +: 2] = 2'($urandom_range(3));
                if ($urandom_range(99) < 5)
                    max_val[c*W +: W] = ($urandom_range(3) == 0) ? W'($urandom) : W'($urandom_range(12));
                load_val[c*W +: W] = W'($urandom);
            end
            tick();
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
